// File: rtl/atmega_pio_pcint.sv
`default_nettype none
// ============================================================================
// atmega_pio_pcint : ATmega-style GPIO port with PINx toggle-write, pull-ups
// and an optional pin-change interrupt, enabled by ATMEGA_PIO_PCINT_EN.
// Revision: 1.0
// ============================================================================
module atmega_pio_pcint #(
  parameter int          BUS_ADDR_DATA_LEN = 16,
  parameter int          WIDTH             = 8,
  parameter int          PORT_ADDR         = 0,
  parameter int          DDR_ADDR          = 1,
  parameter int          PIN_ADDR          = 2,
  parameter int          PCMSK_ADDR        = 3,
  parameter int          PCIFR_ADDR        = 4,
  parameter logic [7:0]  PINMASK           = 8'hFF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [BUS_ADDR_DATA_LEN-1:0] addr,
  input  logic                         wr,
  input  logic                         rd,
  input  logic [7:0]                   bus_in,
  output logic [7:0]                   bus_out,
  input  logic [7:0]                   io_in,
  output logic [7:0]                   io_out,
  output logic [7:0]                   io_dir,
  output logic [7:0]                   io_pullup,
  output logic                         irq,
  input  logic                         irq_ack
);

  localparam logic [7:0] VALID = PINMASK & 8'((1 << WIDTH) - 1);

  localparam logic [BUS_ADDR_DATA_LEN-1:0] A_PORT = BUS_ADDR_DATA_LEN'(PORT_ADDR);
  localparam logic [BUS_ADDR_DATA_LEN-1:0] A_DDR  = BUS_ADDR_DATA_LEN'(DDR_ADDR);
  localparam logic [BUS_ADDR_DATA_LEN-1:0] A_PIN  = BUS_ADDR_DATA_LEN'(PIN_ADDR);

  logic       sel_port, sel_ddr, sel_pin;
  logic [7:0] port_q, ddr_q, sync1, sync2;
  logic [7:0] wdata;
  logic [7:0] pcmsk_rd, pcifr_rd;
  logic       pcmsk_hit, pcifr_hit;

  assign sel_port = (addr == A_PORT);
  assign sel_ddr  = (addr == A_DDR);
  assign sel_pin  = (addr == A_PIN);
  assign wdata    = bus_in & VALID;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      port_q <= 8'h00;
      ddr_q  <= 8'h00;
      sync1  <= 8'h00;
      sync2  <= 8'h00;
    end else begin
      // PIN write flips PORT bits instead of loading them
      if (wr && sel_port)
        port_q <= wdata;
      else if (wr && sel_pin)
        port_q <= port_q ^ wdata;
      if (wr && sel_ddr)
        ddr_q <= wdata;
      sync1 <= io_in & VALID;
      sync2 <= sync1;
    end
  end

  assign io_out    = ddr_q & port_q & VALID;
  assign io_dir    = ddr_q & VALID;
  assign io_pullup = ~ddr_q & port_q & VALID;

`ifdef ATMEGA_PIO_PCINT_EN
  localparam logic [BUS_ADDR_DATA_LEN-1:0] A_PCMSK = BUS_ADDR_DATA_LEN'(PCMSK_ADDR);
  localparam logic [BUS_ADDR_DATA_LEN-1:0] A_PCIFR = BUS_ADDR_DATA_LEN'(PCIFR_ADDR);

  logic [7:0] prev, pcmsk_q, chg;
  logic       pcif_q, pc_set, pc_clr;

  assign pcmsk_hit = (addr == A_PCMSK);
  assign pcifr_hit = (addr == A_PCIFR);
  // mask in use this cycle is the registered one, so a same-cycle write sees the old mask
  assign chg    = (sync2 ^ prev) & pcmsk_q;
  assign pc_set = |chg;
  assign pc_clr = (wr && pcifr_hit && bus_in[0]) || irq_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev    <= 8'h00;
      pcmsk_q <= 8'h00;
      pcif_q  <= 1'b0;
    end else begin
      prev <= sync2;
      if (wr && pcmsk_hit)
        pcmsk_q <= wdata;
      if (pc_set)
        pcif_q <= 1'b1;
      else if (pc_clr)
        pcif_q <= 1'b0;
    end
  end

  assign pcmsk_rd = pcmsk_q & VALID;
  assign pcifr_rd = {7'b0, pcif_q};
  assign irq      = pcif_q;
`else
  logic unused_pcint;

  assign pcmsk_hit    = 1'b0;
  assign pcifr_hit    = 1'b0;
  assign pcmsk_rd     = 8'h00;
  assign pcifr_rd     = 8'h00;
  assign irq          = 1'b0;
  assign unused_pcint = irq_ack;
`endif

  always_comb begin
    bus_out = 8'h00;
    if (rd && !rst) begin
      if (sel_port)
        bus_out = port_q & VALID;
      else if (sel_ddr)
        bus_out = ddr_q & VALID;
      else if (sel_pin)
        bus_out = sync2 & VALID;
      else if (pcmsk_hit)
        bus_out = pcmsk_rd;
      else if (pcifr_hit)
        bus_out = pcifr_rd;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_atmega_pio_pcint.sv
`default_nettype none
// ============================================================================
// tb_atmega_pio_pcint : randomized bench for atmega_pio_pcint (full port and
// a WIDTH=4 port) against a behavioural model. Revision: 1.0
// ============================================================================
module tb_atmega_pio_pcint;

`ifdef ATMEGA_PIO_PCINT_EN
  localparam bit PC_EN = 1'b1;
`else
  localparam bit PC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic        wr, rd, irq_ack;
  logic [7:0]  bus_in, io_in;

  wire  [7:0]  bo0, out0, dir0, pu0;
  wire  [7:0]  bo1, out1, dir1, pu1;
  wire         irq0, irq1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  atmega_pio_pcint u_dut0 (
    .clk(clk), .rst(rst), .addr(addr), .wr(wr), .rd(rd), .bus_in(bus_in),
    .bus_out(bo0), .io_in(io_in), .io_out(out0), .io_dir(dir0),
    .io_pullup(pu0), .irq(irq0), .irq_ack(irq_ack)
  );

  atmega_pio_pcint #(.WIDTH(4), .PINMASK(8'hFF)) u_dut1 (
    .clk(clk), .rst(rst), .addr(addr), .wr(wr), .rd(rd), .bus_in(bus_in),
    .bus_out(bo1), .io_in(io_in), .io_out(out1), .io_dir(dir1),
    .io_pullup(pu1), .irq(irq1), .irq_ack(irq_ack)
  );

  // ---------------- reference model ----------------
  // hist[i][0] = pad value seen at the latest edge, [1] one edge older, [2] two older.
  logic [7:0] m_port[2], m_ddr[2], m_mask[2];
  logic [7:0] hist[2][3];
  logic       m_pcif[2];

  function automatic logic [7:0] valid_of(input int i);
    return (i == 0) ? 8'hFF : 8'h0F;
  endfunction

  function automatic logic [7:0] nxt_port(input int i);
    if (wr && addr == 16'd0) return bus_in & valid_of(i);
    if (wr && addr == 16'd2) return m_port[i] ^ (bus_in & valid_of(i));
    return m_port[i];
  endfunction

  function automatic logic [7:0] nxt_ddr(input int i);
    if (wr && addr == 16'd1) return bus_in & valid_of(i);
    return m_ddr[i];
  endfunction

  function automatic logic [7:0] nxt_mask(input int i);
    if (PC_EN && wr && addr == 16'd3) return bus_in & valid_of(i);
    return m_mask[i];
  endfunction

  function automatic logic nxt_pcif(input int i);
    logic edge_seen, clear;
    edge_seen = |((hist[i][1] ^ hist[i][2]) & m_mask[i]);
    clear     = (wr && addr == 16'd4 && bus_in[0]) || irq_ack;
    if (!PC_EN)    return 1'b0;
    if (edge_seen) return 1'b1;
    if (clear)     return 1'b0;
    return m_pcif[i];
  endfunction

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_port[i] <= 8'h00; m_ddr[i] <= 8'h00; m_mask[i] <= 8'h00; m_pcif[i] <= 1'b0;
        hist[i][0] <= 8'h00; hist[i][1] <= 8'h00; hist[i][2] <= 8'h00;
      end else begin
        m_port[i]  <= nxt_port(i);
        m_ddr[i]   <= nxt_ddr(i);
        m_mask[i]  <= nxt_mask(i);
        m_pcif[i]  <= nxt_pcif(i);
        hist[i][0] <= io_in & valid_of(i);
        hist[i][1] <= hist[i][0];
        hist[i][2] <= hist[i][1];
      end
    end
  end

  function automatic logic [7:0] exp_bus(input int i);
    if (rst || !rd) return 8'h00;
    case (addr)
      16'd0:   return m_port[i];
      16'd1:   return m_ddr[i];
      16'd2:   return hist[i][1];
      16'd3:   return PC_EN ? m_mask[i] : 8'h00;
      16'd4:   return PC_EN ? {7'b0, m_pcif[i]} : 8'h00;
      default: return 8'h00;
    endcase
  endfunction

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got=%02h expected=%02h", tag, $time, got, exp);
    end
  endtask

  task automatic check_all();
    check_eq("bus0",  bo0,  exp_bus(0));
    check_eq("out0",  out0, m_ddr[0] & m_port[0]);
    check_eq("dir0",  dir0, m_ddr[0]);
    check_eq("pu0",   pu0,  ~m_ddr[0] & m_port[0]);
    check_eq("irq0",  {7'b0, irq0}, {7'b0, m_pcif[0]});
    check_eq("bus1",  bo1,  exp_bus(1));
    check_eq("out1",  out1, m_ddr[1] & m_port[1]);
    check_eq("dir1",  dir1, m_ddr[1]);
    check_eq("pu1",   pu1,  ~m_ddr[1] & m_port[1]);
    check_eq("irq1",  {7'b0, irq1}, {7'b0, m_pcif[1]});
  endtask

  task automatic check_reset_zero();
    check_eq("rst_bus0", bo0, 8'h00);
    check_eq("rst_out0", out0 | dir0 | pu0, 8'h00);
    check_eq("rst_irq0", {7'b0, irq0}, 8'h00);
    check_eq("rst_bus1", bo1, 8'h00);
    check_eq("rst_out1", out1 | dir1 | pu1 | {7'b0, irq1}, 8'h00);
  endtask

  // drive one cycle of bus activity, then compare before the next rising edge
  task automatic step(input logic [15:0] a, input logic w, input logic r,
                      input logic [7:0] d, input logic [7:0] pads, input logic ack);
    @(negedge clk);
    addr = a; wr = w; rd = r; bus_in = d; io_in = pads; irq_ack = ack;
    #1;
    check_all();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] pads;
    rst = 1'b1; addr = 16'd0; wr = 1'b0; rd = 1'b1; bus_in = 8'h00;
    io_in = 8'h00; irq_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_reset_zero();
    @(negedge clk);
    rst = 1'b0;
    pads = 8'h00;

    step(16'd1, 1, 0, 8'h0F, pads, 0);
    step(16'd0, 1, 0, 8'hA5, pads, 0);
    step(16'd0, 0, 1, 8'h00, pads, 0);
    check_eq("io_out_05", out0, 8'h05);
    check_eq("io_dir_0f", dir0, 8'h0F);
    check_eq("io_pu_a0",  pu0,  8'hA0);
    check_eq("rd_port",   bo0,  8'hA5);
    step(16'd1, 0, 1, 8'h00, pads, 0);
    check_eq("rd_ddr",    bo0,  8'h0F);

    step(16'd2, 1, 0, 8'h81, pads, 0);
    step(16'd0, 0, 1, 8'h00, pads, 0);
    check_eq("toggle_24", bo0,  8'h24);
    check_eq("toggle_out", out0, 8'h04);
    step(16'd2, 1, 0, 8'h81, pads, 0);
    step(16'd0, 0, 1, 8'h00, pads, 0);
    check_eq("toggle_back", bo0, 8'hA5);

    step(16'd0, 1, 0, 8'hFF, pads, 0);
    step(16'd0, 0, 1, 8'h00, pads, 0);
    check_eq("w4_port", bo1, 8'h0F);
    pads = 8'hFF;
    step(16'd2, 0, 1, 8'h00, pads, 0);
    step(16'd2, 0, 1, 8'h00, pads, 0);
    step(16'd2, 0, 1, 8'h00, pads, 0);
    check_eq("w4_pin", bo1, 8'h0F);
    check_eq("w8_pin", bo0, 8'hFF);

    // pin-change on a masked pin, then an unmasked one
    step(16'd3, 1, 0, 8'h04, pads, 0);
    pads ^= 8'h04;
    step(16'd4, 0, 1, 8'h00, pads, 0);
    step(16'd4, 0, 1, 8'h00, pads, 0);
    check_eq("irq_early", {7'b0, irq0}, 8'h00);
    step(16'd4, 0, 1, 8'h00, pads, 0);
    check_eq("irq_early2", {7'b0, irq0}, 8'h00);
    step(16'd3, 0, 1, 8'h00, pads, 0);
    check_eq("irq_edge", {7'b0, irq0}, {7'b0, PC_EN});
    check_eq("pcmsk_rd", bo0, PC_EN ? 8'h04 : 8'h00);
    step(16'd0, 0, 0, 8'h00, pads, 1);
    pads ^= 8'h08;
    step(16'd0, 0, 0, 8'h00, pads, 0);
    repeat (3) step(16'd0, 0, 0, 8'h00, pads, 0);
    check_eq("irq_unmasked", {7'b0, irq0}, 8'h00);

    // second edge lands in the same cycle as a PCIFR clear: set wins
    pads ^= 8'h04;
    step(16'd0, 0, 0, 8'h00, pads, 0);
    pads ^= 8'h04;
    step(16'd0, 0, 0, 8'h00, pads, 0);
    step(16'd0, 0, 0, 8'h00, pads, 0);
    step(16'd4, 1, 0, 8'h01, pads, 0);
    step(16'd4, 0, 1, 8'h00, pads, 0);
    check_eq("set_wins", {7'b0, irq0}, {7'b0, PC_EN});
    step(16'd0, 0, 0, 8'h00, pads, 1);
    step(16'd0, 0, 0, 8'h00, pads, 0);
    check_eq("ack_clear", {7'b0, irq0}, 8'h00);

    // randomized traffic with occasional asynchronous reset
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] a;
      if ($urandom_range(0, 199) == 0) begin
        @(negedge clk);
        rst = 1'b1; rd = 1'b1; addr = 16'd0;
        #1 check_reset_zero();
        @(negedge clk);
        rst = 1'b0;
      end
      a = ($urandom_range(0, 15) == 0) ? 16'($urandom) : 16'($urandom_range(0, 6));
      if ($urandom_range(0, 2) == 0) pads = pads ^ (8'd1 << $urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) pads = 8'($urandom);
      step(a, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
           8'($urandom), pads, $urandom_range(0, 15) == 0);
    end

    @(negedge clk);
    wr = 1'b0; irq_ack = 1'b0;
    #1 check_all();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
